fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the word address into instruction memory.
- Takes the returned instruction word and registers it, together with its PC and PC+8, into the IF/ID pipeline register.
- Computes the next PC for branch, jump and jr redirects using the D-stage PC (architectural delay slot, no squash).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IMEM_BASE, 32'h0000_3000, lowest valid fetch address.
- IMEM_WORDS, 4096, instruction memory depth in words.

Ports:
- clk  in  1  single rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
- stall  in  1  from hazard unit; freezes the PC and the IF/ID register
- clr  in  1  loads a bubble into IF/ID
- npc_sel  in  2  00 seq, 01 branch, 10 j/jal, 11 jr
- br_taken  in  1  branch comparison result (D stage)
- d_imm16  in  16  branch offset field of the D instruction
- d_index26  in  26  jump index field of the D instruction
- jr_target  in  32  forwarded rs value for jr/jalr
- imem_addr  out  32  fetch address to instruction memory (= F_pc)
- imem_instr  in  32  instruction word returned combinationally
- d_instr  out  32  IF/ID instruction
- d_pc  out  32  IF/ID PC
- d_pc8  out  32  IF/ID PC+8 (link value)
- d_valid  out  1  IF/ID holds a real instruction
- d_addr_err  out  1  fetch-address fault flag (see Optional Feature)

Behaviour:
- Reset (reset==0 at the edge) overrides everything, including stall:
  - F_pc=RESET_PC.
  - d_instr=0, d_pc=0, d_pc8=0, d_valid=0, d_addr_err=0.
- imem_addr = F_pc, combinational. The memory is asynchronous, so the instruction is available in the same cycle (zero-cycle fetch latency). IF/ID is one register stage.
- NPC, combinational. All adds are 32-bit and wrap modulo 2^32.
  - seq: F_pc+4.
  - branch: if br_taken, d_pc+4+sext(d_imm16)<<2; otherwise F_pc+4.
  - j/jal: {d_pc_plus4[31:28], d_index26, 2'b00}, where d_pc_plus4 = d_pc+4.
  - jr: jr_target, used unmodified.
  - If d_valid==0, npc_sel is ignored and seq is used. Redirects never originate from bubbles.
- Priority per edge: reset > stall > clr > normal.
  - stall=1: F_pc and all d_* registers hold, even if clr=1. No instruction is lost. The imem_addr output stays constant.
  - clr=1, stall=0: F_pc<=NPC; d_instr<=0 (nop); d_pc and d_pc8 <= 0; d_valid<=0.
  - Normal: F_pc<=NPC; d_instr<=imem_instr; d_pc<=F_pc; d_pc8<=F_pc+8; d_valid<=1.
- Delay slot: the instruction fetched in the same cycle a redirect is resolved is always kept.
- A redirect asserted during stall has no effect that cycle. The hazard unit re-presents it once the stall clears.
- No internal state machine beyond PC/IF-ID. Behaviour is fully determined by the current registers and inputs.

Optional Feature:
Macro FETCH_ADDR_CHECK_EN.
- Defined: the fetch is faulty if F_pc[1:0]!=0, or F_pc<IMEM_BASE, or F_pc>=IMEM_BASE+4*IMEM_WORDS. On a normal (non-stall, non-clr) edge with a faulty fetch:
  - d_instr<=0.
  - d_addr_err<=1.
  - d_valid<=1, so the exception logic sees the PC.
  - d_pc<=F_pc.
  Otherwise d_addr_err<=0.
- Not defined: d_addr_err is tied to 0 and imem_instr is always passed through.

Decomposition:
- Shared package holds:
  - NPC_SEL_SEQ/BR/J/JR codes.
  - RESET_PC and IMEM_BASE defaults.
  - NOP encoding (32'h0).
- One combinational sub-module, npc_calc: computes NPC from F_pc, d_pc, d_valid, npc_sel, br_taken, d_imm16, d_index26 and jr_target.

Test Plan:
- Reset then release, 3 free cycles -> imem_addr 0x300C, d_pc 0x3008, d_pc8 0x3010, d_valid 1.
- d_pc=0x3004, npc_sel=01, br_taken=1, d_imm16=0xFFFF -> next F_pc 0x3004; delay-slot instruction at 0x3008 reaches IF/ID.
- d_pc=0x3010, npc_sel=10, d_index26=0x0000C10 -> next F_pc 0x0000_3040.
- stall=1 for 2 cycles with clr=1 and npc_sel=11 -> F_pc and d_* unchanged. Release with clr=0 -> normal advance.
- clr=1, stall=0 -> d_instr 0, d_valid 0, F_pc advances to F_pc+4. Reset asserted while stall=1 -> F_pc 0x3000.
- FETCH_ADDR_CHECK_EN, jr_target=0x3002 -> next edge d_addr_err 1, d_instr 0, d_pc 0x3002. Without the macro -> d_addr_err stays 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// fetch_unit shared types: NPC select codes, IF/ID bundle,
// reset/base defaults and the NOP encoding.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    NPC_SEL_SEQ = 2'b00,
    NPC_SEL_BR  = 2'b01,
    NPC_SEL_J   = 2'b10,
    NPC_SEL_JR  = 2'b11
  } npc_sel_e;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS_DEF = 4096;
  localparam logic [31:0] NOP            = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        addr_err;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// fetch_unit_npc_calc: next-PC selection for seq, branch,
// j/jal and jr; redirects only from a valid D instruction.
module fetch_unit_npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic        d_valid_i,
  input  logic [1:0]  npc_sel_i,
  input  logic        br_taken_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_index26_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] npc_o
);

  logic [31:0] seq_pc;
  logic [31:0] d_pc4;
  logic [31:0] br_off;

  assign seq_pc = f_pc_i + 32'd4;
  assign d_pc4  = d_pc_i + 32'd4;
  assign br_off = {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};

  // Pick the redirect target; bubbles always fall through to seq.
  always_comb begin
    npc_o = seq_pc;
    if (d_valid_i) begin
      unique case (npc_sel_e'(npc_sel_i))
        NPC_SEL_SEQ: npc_o = seq_pc;
        NPC_SEL_BR: begin
          if (br_taken_i) npc_o = d_pc4 + br_off;
        end
        NPC_SEL_J:  npc_o = {d_pc4[31:28], d_index26_i, 2'b00};
        NPC_SEL_JR: npc_o = jr_target_i;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, async imem fetch, IF/ID register.
// FETCH_ADDR_CHECK_EN enables the fetch-address fault flag.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic        d_addr_err
);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic ADDR_CHECK = 1'b1;
`else
  localparam logic ADDR_CHECK = 1'b0;
`endif

  localparam logic [32:0] IMEM_END =
    {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] npc;
  if_id_t      if_id_q, if_id_d;
  logic        addr_fault;

  fetch_unit_npc_calc u_npc_calc (
    .f_pc_i      (f_pc_q),
    .d_pc_i      (if_id_q.pc),
    .d_valid_i   (if_id_q.valid),
    .npc_sel_i   (npc_sel),
    .br_taken_i  (br_taken),
    .d_imm16_i   (d_imm16),
    .d_index26_i (d_index26),
    .jr_target_i (jr_target),
    .npc_o       (npc)
  );

  assign addr_fault = ADDR_CHECK &&
    ((f_pc_q[1:0] != 2'b00) ||
     ({1'b0, f_pc_q} < {1'b0, IMEM_BASE}) ||
     ({1'b0, f_pc_q} >= IMEM_END));

  // Next state: stall holds all, clr inserts a bubble.
  always_comb begin
    f_pc_d  = f_pc_q;
    if_id_d = if_id_q;
    if (!stall) begin
      f_pc_d = npc;
      if (clr) begin
        if_id_d       = '0;
        if_id_d.instr = NOP;
      end else begin
        if_id_d.instr    = addr_fault ? NOP : imem_instr;
        if_id_d.pc       = f_pc_q;
        if_id_d.pc8      = f_pc_q + 32'd8;
        if_id_d.valid    = 1'b1;
        if_id_d.addr_err = addr_fault;
      end
    end
  end

  // PC and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_pc_q        <= RESET_PC;
      if_id_q       <= '0;
      if_id_q.instr <= NOP;
    end else begin
      f_pc_q  <= f_pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem_addr  = f_pc_q;
  assign d_instr    = if_id_q.instr;
  assign d_pc       = if_id_q.pc;
  assign d_pc8      = if_id_q.pc8;
  assign d_valid    = if_id_q.valid;
  assign d_addr_err = if_id_q.addr_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed steps, per-cycle scoreboard of
// expected outputs plus fixed-value checks at key points.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, clr, br_taken;
  logic [1:0]  npc_sel;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] jr_target, imem_addr, imem_instr;
  logic [31:0] d_instr, d_pc, d_pc8;
  logic        d_valid, d_addr_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];

  logic [31:0] m_fpc, m_instr, m_pc, m_pc8;
  logic        m_valid, m_err;

`ifdef FETCH_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  assign imem_instr = imem_addr ^ 32'hDEAD_0000;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .clr        (clr),
    .npc_sel    (npc_sel),
    .br_taken   (br_taken),
    .d_imm16    (d_imm16),
    .d_index26  (d_index26),
    .jr_target  (jr_target),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .d_pc8      (d_pc8),
    .d_valid    (d_valid),
    .d_addr_err (d_addr_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_npc();
    logic [31:0] t;
    logic [31:0] dp4;
    t   = m_fpc + 32'd4;
    dp4 = m_pc + 32'd4;
    if (m_valid) begin
      if (npc_sel == 2'b01 && br_taken)
        t = dp4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
      else if (npc_sel == 2'b10)
        t = {dp4[31:28], d_index26, 2'b00};
      else if (npc_sel == 2'b11)
        t = jr_target;
    end
    return t;
  endfunction

  // Advance the model, queue its prediction, clock, compare.
  task automatic step();
    exp_t e;
    logic flt;
    flt = CHK && (m_fpc[1:0] != 0 || m_fpc < 32'h3000 ||
                  m_fpc >= 32'h7000);
    if (!reset) begin
      m_fpc = 32'h3000; m_instr = 0; m_pc = 0;
      m_pc8 = 0; m_valid = 0; m_err = 0;
    end else if (!stall) begin
      logic [31:0] n;
      n = model_npc();
      if (clr) begin
        m_instr = 0; m_pc = 0; m_pc8 = 0;
        m_valid = 0; m_err = 0;
      end else begin
        m_instr = flt ? 32'h0 : (m_fpc ^ 32'hDEAD_0000);
        m_pc = m_fpc; m_pc8 = m_fpc + 32'd8;
        m_valid = 1; m_err = flt;
      end
      m_fpc = n;
    end
    e.addr = m_fpc; e.instr = m_instr; e.pc = m_pc;
    e.pc8 = m_pc8; e.valid = m_valid; e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_addr",  imem_addr, e.addr);
    chk("sb_instr", d_instr,   e.instr);
    chk("sb_pc",    d_pc,      e.pc);
    chk("sb_pc8",   d_pc8,     e.pc8);
    chk("sb_valid", {31'b0, d_valid},    {31'b0, e.valid});
    chk("sb_err",   {31'b0, d_addr_err}, {31'b0, e.err});
  endtask

  task automatic idle();
    stall = 0; clr = 0; npc_sel = 2'b00; br_taken = 0;
  endtask

  initial begin
    reset = 0; idle();
    d_imm16 = 0; d_index26 = 0; jr_target = 0;
    m_fpc = 0; m_instr = 0; m_pc = 0;
    m_pc8 = 0; m_valid = 0; m_err = 0;

    // reset state
    step();
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_valid", {31'b0, d_valid}, 32'h0);
    chk("rst_pc", d_pc, 32'h0);

    // three free cycles
    reset = 1;
    repeat (3) step();
    chk("free_addr", imem_addr, 32'h300C);
    chk("free_pc", d_pc, 32'h3008);
    chk("free_pc8", d_pc8, 32'h3010);
    chk("free_valid", {31'b0, d_valid}, 32'h1);

    // taken branch back by one word, delay slot kept
    reset = 0; step(); reset = 1;
    repeat (2) step();
    chk("pre_br_pc", d_pc, 32'h3004);
    npc_sel = 2'b01; br_taken = 1; d_imm16 = 16'hFFFF;
    step();
    idle();
    chk("br_addr", imem_addr, 32'h3004);
    chk("br_slot_pc", d_pc, 32'h3008);
    chk("br_slot_instr", d_instr, 32'hDEAD_3008);

    // walk d_pc to 0x3010, then jump
    repeat (4) step();
    chk("pre_j_pc", d_pc, 32'h3010);
    npc_sel = 2'b10; d_index26 = 26'h0000C10;
    step();
    idle();
    chk("j_addr", imem_addr, 32'h3040);

    // stall with clr and jr pending holds everything
    stall = 1; clr = 1; npc_sel = 2'b11;
    jr_target = 32'h5555_0000;
    repeat (2) step();
    chk("stall_addr", imem_addr, 32'h3040);
    chk("stall_pc", d_pc, 32'h3014);
    idle();
    step();
    chk("rel_addr", imem_addr, 32'h3044);
    chk("rel_pc", d_pc, 32'h3040);

    // bubble, then redirect from a bubble is ignored
    clr = 1;
    step();
    clr = 0;
    chk("clr_instr", d_instr, 32'h0);
    chk("clr_valid", {31'b0, d_valid}, 32'h0);
    chk("clr_addr", imem_addr, 32'h3048);
    npc_sel = 2'b11; jr_target = 32'h0000_3100;
    step();
    idle();
    chk("bub_addr", imem_addr, 32'h304C);

    // reset wins over stall
    stall = 1; reset = 0;
    step();
    chk("rst_stall_addr", imem_addr, 32'h3000);
    reset = 1; stall = 0;

    // misaligned jr target
    step();
    npc_sel = 2'b11; jr_target = 32'h0000_3002;
    step();
    idle();
    chk("jr_addr", imem_addr, 32'h3002);
    step();
    chk("ae_pc", d_pc, 32'h3002);
    chk("ae_err", {31'b0, d_addr_err}, {31'b0, CHK});
    chk("ae_instr", d_instr, CHK ? 32'h0 : 32'hDEAD_3002);
    chk("ae_valid", {31'b0, d_valid}, 32'h1);

    // branch not taken, then wrap at the top of memory
    npc_sel = 2'b01; br_taken = 0; d_imm16 = 16'h0040;
    step();
    chk("bnt_addr", imem_addr, 32'h300A);
    npc_sel = 2'b11; jr_target = 32'hFFFF_FFFC;
    step();
    idle();
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc8", d_pc8, 32'h4);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
